// File: rtl/mac_bus_pkg.sv
// mac_bus_pkg: shared types and constants for the Mac Plus bus controller.
// Holds the region/state encodings, the address map and default wait states.
package mac_bus_pkg;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_RAM,
        RG_ROM,
        RG_SCSI,
        RG_SCC,
        RG_IWM,
        RG_VIA,
        RG_IACK
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_BERR
    } state_t;

    localparam logic [23:0] RAM_BASE  = 24'h000000;
    localparam logic [23:0] RAM_MASK  = 24'hC00000;
    localparam logic [23:0] ROM_BASE  = 24'h400000;
    localparam logic [23:0] ROM_MASK  = 24'hF00000;
    localparam logic [23:0] SCSI_BASE = 24'h580000;
    localparam logic [23:0] SCSI_MASK = 24'hF80000;
    localparam logic [23:0] SCCR_BASE = 24'h800000;
    localparam logic [23:0] SCCW_BASE = 24'hA00000;
    localparam logic [23:0] SCC_MASK  = 24'hE00000;
    localparam logic [23:0] IWM_BASE  = 24'hC00000;
    localparam logic [23:0] IWM_MASK  = 24'hE00000;
    localparam logic [23:0] VIA_BASE  = 24'hE80000;
    localparam logic [23:0] VIA_MASK  = 24'hF80000;

    localparam int DEF_ROM_WS  = 1;
    localparam int DEF_SCSI_WS = 2;
    localparam int DEF_TMO     = 63;

    localparam int WS_W = 4;
    localparam int WD_W = 6;

    function automatic logic addr_hit(
        input logic [23:0] a,
        input logic [23:0] base,
        input logic [23:0] mask
    );
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/mac_addr_decode.sv
// mac_addr_decode: combinational CPU cycle -> region decode.
// Earlier tests take priority; IACK overrides any address.
module mac_addr_decode
    import mac_bus_pkg::*;
(
    input  logic [23:0] i_addr,
    input  logic [2:0]  i_fc,
    input  logic        i_rw_n,
    input  logic        i_overlay,
    output logic [2:0]  o_region
);

    region_t w_region;

    always_comb begin
        w_region = RG_NONE;
        if (i_fc == 3'b111)
            w_region = RG_IACK;
        else if (addr_hit(i_addr, RAM_BASE, RAM_MASK))
            w_region = i_overlay ? RG_ROM : RG_RAM;
        else if (addr_hit(i_addr, ROM_BASE, ROM_MASK))
            w_region = RG_ROM;
        else if (addr_hit(i_addr, SCSI_BASE, SCSI_MASK))
            w_region = RG_SCSI;
        else if (i_rw_n && addr_hit(i_addr, SCCR_BASE, SCC_MASK))
            w_region = RG_SCC;
        else if (!i_rw_n && addr_hit(i_addr, SCCW_BASE, SCC_MASK))
            w_region = RG_SCC;
        else if (addr_hit(i_addr, IWM_BASE, IWM_MASK))
            w_region = RG_IWM;
        else if (addr_hit(i_addr, VIA_BASE, VIA_MASK))
            w_region = RG_VIA;
    end

    assign o_region = w_region;

endmodule

// File: rtl/mac_bus_ctrl.sv
// mac_bus_ctrl: 68000 slave bus controller for the Mac Plus memory map.
// Define BUS_TIMEOUT_EN to enable the watchdog and bus-error path.
module mac_bus_ctrl
    import mac_bus_pkg::*;
#(
    parameter int ROM_WS  = DEF_ROM_WS,
    parameter int SCSI_WS = DEF_SCSI_WS,
    parameter int TMO     = DEF_TMO
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi1,
    input  logic        phi2,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw_n,
    input  logic [2:0]  fc,
    input  logic [23:0] addr,
    input  logic        overlay,
    input  logic        ram_ready,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr,
    output logic        sel_ram,
    output logic        sel_rom,
    output logic        sel_scsi,
    output logic        sel_scc,
    output logic        sel_iwm,
    output logic        sel_via
);

    state_t          r_state;
    state_t          w_state_nxt;
    region_t         r_region;
    region_t         w_region_nxt;
    logic [2:0]      w_dec_raw;
    logic [WS_W-1:0] r_cnt;
    logic [WS_W-1:0] w_cnt_nxt;
    logic [WS_W-1:0] w_ws;
    logic            w_ready;
    logic            w_tmo;
    logic            w_none_err;
    logic [5:0]      w_sel;
    logic            w_dtack_n;
    logic            w_vpa_n;
    logic            w_berr;
    logic [5:0]      r_sel;
    logic            r_dtack_n;
    logic            r_vpa_n;
    logic            r_berr;
    logic            w_unused;

    assign w_unused = ^{phi1, uds_n, lds_n, (TMO != 0)};

    mac_addr_decode u_dec (
        .i_addr    (addr),
        .i_fc      (fc),
        .i_rw_n    (rw_n),
        .i_overlay (overlay),
        .o_region  (w_dec_raw)
    );

    function automatic logic [WS_W-1:0] ws_of(input region_t rg);
        case (rg)
            RG_ROM:  return WS_W'(ROM_WS);
            RG_SCSI: return WS_W'(SCSI_WS);
            default: return '0;
        endcase
    endfunction

`ifdef BUS_TIMEOUT_EN
    logic [WD_W-1:0] r_wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wd <= '0;
        else if (r_state != ST_DECODE && r_state != ST_WAIT)
            r_wd <= '0;
        else if (phi2)
            r_wd <= r_wd + 1'b1;
    end

    assign w_tmo      = (r_wd == WD_W'(TMO - 1));
    assign w_none_err = (r_region == RG_NONE);
`else
    assign w_tmo      = 1'b0;
    assign w_none_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_region <= RG_NONE;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_region <= w_region_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign w_ready = (r_region != RG_RAM) || ram_ready;
    assign w_ws    = ws_of(r_region);

    // A zero-wait region may acknowledge straight out of DECODE;
    // otherwise WAIT is entered already one tick into its wait.
    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_cnt_nxt    = r_cnt;
        if (phi2) begin
            case (r_state)
                ST_IDLE: begin
                    if (!as_n) begin
                        w_state_nxt  = ST_DECODE;
                        w_region_nxt = region_t'(w_dec_raw);
                    end
                end
                ST_DECODE: begin
                    if (as_n)
                        w_state_nxt = ST_IDLE;
                    else if (w_none_err)
                        w_state_nxt = ST_BERR;
                    else if (w_ws == '0 && w_ready)
                        w_state_nxt = ST_ACK;
                    else if (w_tmo)
                        w_state_nxt = ST_BERR;
                    else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = (w_ws == '0) ? '0 : w_ws - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (as_n)
                        w_state_nxt = ST_IDLE;
                    else if (r_cnt == '0 && w_ready)
                        w_state_nxt = ST_ACK;
                    else if (w_tmo)
                        w_state_nxt = ST_BERR;
                    else if (r_cnt != '0)
                        w_cnt_nxt = r_cnt - 1'b1;
                end
                ST_ACK, ST_BERR: begin
                    if (as_n)
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sel     = '0;
        w_dtack_n = 1'b1;
        w_vpa_n   = 1'b1;
        w_berr    = (w_state_nxt == ST_BERR);
        if (w_state_nxt == ST_WAIT || w_state_nxt == ST_ACK ||
            w_state_nxt == ST_BERR) begin
            case (w_region_nxt)
                RG_RAM:  w_sel = 6'b100000;
                RG_ROM:  w_sel = 6'b010000;
                RG_SCSI: w_sel = 6'b001000;
                RG_SCC:  w_sel = 6'b000100;
                RG_IWM:  w_sel = 6'b000010;
                RG_VIA:  w_sel = 6'b000001;
                default: w_sel = 6'b000000;
            endcase
        end
        if (w_state_nxt == ST_ACK) begin
            if (w_region_nxt == RG_VIA || w_region_nxt == RG_IACK)
                w_vpa_n = 1'b0;
            else
                w_dtack_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel     <= '0;
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_berr    <= 1'b0;
        end else begin
            r_sel     <= w_sel;
            r_dtack_n <= w_dtack_n;
            r_vpa_n   <= w_vpa_n;
            r_berr    <= w_berr;
        end
    end

    assign dtack_n  = r_dtack_n;
    assign vpa_n    = r_vpa_n;
    assign berr     = r_berr;
    assign sel_ram  = r_sel[5];
    assign sel_rom  = r_sel[4];
    assign sel_scsi = r_sel[3];
    assign sel_scc  = r_sel[2];
    assign sel_iwm  = r_sel[1];
    assign sel_via  = r_sel[0];

endmodule

// File: tb/tb_mac_bus_ctrl.sv
// tb_mac_bus_ctrl: scoreboard bench for mac_bus_ctrl.
// Expected acknowledge kind, select and latency come from an address-range model.
module tb_mac_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        phi1 = 1'b0;
    logic        phi2 = 1'b0;
    logic        as_n = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic        rw_n = 1'b1;
    logic [2:0]  fc = 3'd6;
    logic [23:0] addr = 24'h0;
    logic        overlay = 1'b1;
    logic        ram_ready = 1'b0;
    logic        dtack_n, vpa_n, berr;
    logic        sel_ram, sel_rom, sel_scsi, sel_scc, sel_iwm, sel_via;

    mac_bus_ctrl dut (
        .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2),
        .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw_n(rw_n),
        .fc(fc), .addr(addr), .overlay(overlay), .ram_ready(ram_ready),
        .dtack_n(dtack_n), .vpa_n(vpa_n), .berr(berr),
        .sel_ram(sel_ram), .sel_rom(sel_rom), .sel_scsi(sel_scsi),
        .sel_scc(sel_scc), .sel_iwm(sel_iwm), .sel_via(sel_via)
    );

    localparam int R_NONE = 0, R_RAM = 1, R_ROM = 2, R_SCSI = 3;
    localparam int R_SCC = 4, R_IWM = 5, R_VIA = 6, R_IACK = 7;
    localparam logic [8:0] IDLE_V = 9'b110_000000;

    typedef struct {
        logic [2:0] kind;
        logic [5:0] sel;
        int         start;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   tick = 0;
    bit   got = 1'b0;
    bit   prev_resp = 1'b0;
    logic [23:0] bnd [21];

    initial forever #5 clk = ~clk;

    initial begin
        int phc;
        phc = 0;
        forever begin
            @(negedge clk);
            phc = (phc + 1) % 4;
            phi1 = (phc == 0);
            phi2 = (phc == 2);
        end
    end

    always @(posedge clk) if (phi2) tick <= tick + 1;

    initial begin
        #1ms;
        $display("FAIL global_timeout: sim still running, want finished");
        $fatal(1, "global timeout");
    end

    function automatic logic [8:0] snap();
        return {dtack_n, vpa_n, berr, sel_ram, sel_rom,
                sel_scsi, sel_scc, sel_iwm, sel_via};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int model_region(input logic [23:0] a, input logic rw,
                                        input logic [2:0] f, input logic ov);
        int v;
        v = int'(a);
        if (f == 3'd7) return R_IACK;
        if (v <= 'h3FFFFF) return ov ? R_ROM : R_RAM;
        if (v <= 'h4FFFFF) return R_ROM;
        if (v >= 'h580000 && v <= 'h5FFFFF) return R_SCSI;
        if (rw && v >= 'h800000 && v <= 'h9FFFFF) return R_SCC;
        if (!rw && v >= 'hA00000 && v <= 'hBFFFFF) return R_SCC;
        if (v >= 'hC00000 && v <= 'hDFFFFF) return R_IWM;
        if (v >= 'hE80000 && v <= 'hEFFFFF) return R_VIA;
        return R_NONE;
    endfunction

    function automatic logic [2:0] model_kind(input int rg);
        if (rg == R_VIA || rg == R_IACK) return 3'b010;
`ifdef BUS_TIMEOUT_EN
        if (rg == R_NONE) return 3'b001;
`endif
        return 3'b100;
    endfunction

    function automatic logic [5:0] model_sel(input int rg);
        if (rg >= R_RAM && rg <= R_VIA) return 6'b100000 >> (rg - 1);
        return 6'b000000;
    endfunction

    function automatic int model_lat(input int rg, input int rdel);
        if (rg == R_RAM) return (rdel + 1 > 2) ? rdel + 1 : 2;
        if (rg == R_ROM) return 3;
        if (rg == R_SCSI) return 4;
        return 2;
    endfunction

    always @(negedge clk) begin
        bit   resp;
        exp_t e;
        resp = !dtack_n || !vpa_n || berr;
        if (resp) begin
            check("excl", int'(!dtack_n) + int'(!vpa_n) + int'(berr), 1);
            check("sel_onehot", int'($countones(snap()) > 4), 0);
        end
        if (resp && !prev_resp) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got %b want none", snap());
            end else begin
                e = sb.pop_front();
                check("kind", {29'd0, !dtack_n, !vpa_n, berr}, e.kind);
                check("sel", {26'd0, snap()[5:0]}, e.sel);
                check("latency", tick - e.start, e.lat);
            end
            got = 1'b1;
        end
        prev_resp = resp;
    end

    task automatic wait_ticks(input int t0, input int n);
        int c;
        c = 0;
        while (tick < t0 + n && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic release_bus();
        as_n = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        wait_ticks(tick, 2);
        check("idle_after", snap(), IDLE_V);
        ram_ready = 1'b0;
    endtask

    task automatic run_cycle(input logic [23:0] a, input logic rw,
                             input logic [2:0] f, input logic ov,
                             input int rdel, input bit flip);
        exp_t e;
        int   rg;
        int   n;
        rg = model_region(a, rw, f, ov);
        @(negedge clk);
        addr = a;
        rw_n = rw;
        fc = f;
        overlay = ov;
        uds_n = 1'b0;
        lds_n = 1'b0;
        ram_ready = (rdel == 0);
        e.kind = model_kind(rg);
        e.sel = model_sel(rg);
        e.start = tick;
        e.lat = model_lat(rg, rdel);
        sb.push_back(e);
        got = 1'b0;
        as_n = 1'b0;
        n = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (tick - e.start >= rdel) ram_ready = 1'b1;
            if (flip && tick - e.start >= 1) overlay = ~ov;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: addr %h no response, want one", a);
        end
        release_bus();
    endtask

    initial begin
        int t0;
        bnd = '{24'h3FFFFE, 24'h400000, 24'h4FFFFE, 24'h500000, 24'h57FFFE,
                24'h580000, 24'h5FFFFE, 24'h600000, 24'h7FFFFE, 24'h800000,
                24'h9FFFFE, 24'hA00000, 24'hBFFFFE, 24'hC00000, 24'hDFFFFE,
                24'hE00000, 24'hE7FFFE, 24'hE80000, 24'hEFFFFE, 24'hF00000,
                24'hFFFFFE};
        repeat (6) @(negedge clk);
        check("reset_state", snap(), IDLE_V);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_cycle(24'h000100, 1'b1, 3'd6, 1'b1, 0, 1'b0);
        run_cycle(24'h000100, 1'b1, 3'd6, 1'b0, 4, 1'b0);
        run_cycle(24'hEFE1FE, 1'b1, 3'd5, 1'b0, 0, 1'b0);
        run_cycle(24'h123456, 1'b1, 3'd7, 1'b0, 0, 1'b0);
        run_cycle(24'hA00000, 1'b0, 3'd5, 1'b0, 0, 1'b0);
        run_cycle(24'hA00000, 1'b1, 3'd5, 1'b0, 0, 1'b0);
        run_cycle(24'h600000, 1'b1, 3'd5, 1'b0, 0, 1'b0);
        run_cycle(24'h580000, 1'b1, 3'd5, 1'b0, 0, 1'b0);
        run_cycle(24'hC00010, 1'b1, 3'd5, 1'b0, 0, 1'b0);
        run_cycle(24'h000400, 1'b1, 3'd6, 1'b0, 0, 1'b1);

        @(negedge clk);
        addr = 24'h000200;
        overlay = 1'b0;
        ram_ready = 1'b1;
        rw_n = 1'b1;
        fc = 3'd6;
        t0 = tick;
        as_n = 1'b0;
        wait_ticks(t0, 1);
        as_n = 1'b1;
        wait_ticks(t0, 4);
        check("abort_idle", snap(), IDLE_V);
        ram_ready = 1'b0;

        @(negedge clk);
        addr = 24'h5A0000;
        rw_n = 1'b1;
        fc = 3'd5;
        t0 = tick;
        as_n = 1'b0;
        wait_ticks(t0, 2);
        check("scsi_wait", snap(), 9'b110_001000);
        reset = 1'b1;
        as_n = 1'b1;
        #1;
        check("reset_in_wait", snap(), IDLE_V);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_cycle(24'h001000, 1'b1, 3'd6, 1'b0, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [23:0] a;
            logic [2:0]  f;
            if ($urandom_range(1, 0) == 1)
                a = 24'($urandom());
            else
                a = bnd[$urandom_range(20, 0)];
            a[0] = 1'b0;
            if ($urandom_range(9, 0) == 0)
                f = 3'd7;
            else
                f = 3'($urandom_range(6, 0));
            run_cycle(a, 1'($urandom_range(1, 0)), f,
                      1'($urandom_range(1, 0)), $urandom_range(5, 0),
                      1'($urandom_range(1, 0)));
        end

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
